alu_seq: RTL

- Sequential front-end for the team's 4-bit combinational ALU core.
- Accepts operation requests (a, b, op) over a valid/ready handshake and registers the operands.
- Computes the result and the N/Z/C/V flags, then holds them on a valid/ready result port until consumed.
- Supports result chaining, where the previous result replaces operand a, and counts completed operations.
- Sits between an instruction/sequencer source and any consumer of ALU results.

---
 rtl/alu_seq_pkg.sv | 21 ++
 rtl/alu_seq_core.sv | 61 ++++++
 rtl/alu_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU front-end: op codes and FSM states.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_SHR = 3'd2,
    ALU_SHL = 3'd3,
    ALU_AND = 3'd4,
    ALU_OR  = 3'd5,
    ALU_XOR = 3'd6,
    ALU_RSV = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_core.sv
// Combinational ALU core: result plus N/Z/C/V flags for one operation.
// The reserved op yields zero result and zero C/V; masking is done by the caller.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  op_e               op,
  output logic [DATA_W-1:0] res,
  output logic              N,
  output logic              Z,
  output logic              C,
  output logic              V
);

  localparam int MSB = DATA_W - 1;

  // One extra bit on the operands exposes carry-out / borrow.
  logic [DATA_W:0] sum_ext;
  logic [DATA_W:0] dif_ext;

  assign sum_ext = {1'b0, a} + {1'b0, b};
  assign dif_ext = {1'b0, a} - {1'b0, b};

  // Operation select; overflow only defined for the arithmetic ops.
  always_comb begin
    res = '0;
    C   = 1'b0;
    V   = 1'b0;
    case (op)
      ALU_ADD: begin
        res = sum_ext[MSB:0];
        C   = sum_ext[DATA_W];
        V   = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        res = dif_ext[MSB:0];
        C   = ~dif_ext[DATA_W];
        V   = (a[MSB] != b[MSB]) && (dif_ext[MSB] != a[MSB]);
      end
      ALU_SHR: begin
        res = {1'b0, a[MSB:1]};
        C   = a[0];
      end
      ALU_SHL: begin
        res = {a[MSB-1:0], 1'b0};
        C   = a[MSB];
      end
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_XOR: res = a ^ b;
      default: res = '0;
    endcase
  end

  assign N = res[MSB];
  assign Z = (res == '0);

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU front-end: request handshake, one-cycle execute,
// held result with handshake, result chaining and completed-op counter.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic [2:0]    in_op,
  input  logic          in_chain,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_res,
  output logic          out_n,
  output logic          out_z,
  output logic          out_c,
  output logic          out_v,
  output logic          out_err,
  output logic [CW-1:0] op_count
);

  state_e       state;
  logic [N-1:0] op_a_p0;
  logic [N-1:0] op_b_p0;
  op_e          op_p0;
  logic [N-1:0] acc_q;
  logic         accept;

  logic [N-1:0] core_res;
  logic         core_n;
  logic         core_z;
  logic         core_c;
  logic         core_v;

  // A new request may enter while the held result is being consumed.
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  alu_seq_core #(
    .DATA_W (N)
  ) u_core (
    .a   (op_a_p0),
    .b   (op_b_p0),
    .op  (op_p0),
    .res (core_res),
    .N   (core_n),
    .Z   (core_z),
    .C   (core_c),
    .V   (core_v)
  );

  // ---- stage p0: operand capture on handshake (data path, no reset) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a_p0 <= in_chain ? acc_q : in_a;
      op_b_p0 <= in_b;
      op_p0   <= op_e'(in_op);
    end
  end

  // ---- control FSM and registered result/flag outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_n     <= 1'b0;
      out_z     <= 1'b0;
      out_c     <= 1'b0;
      out_v     <= 1'b0;
      out_err   <= 1'b0;
      op_count  <= '0;
      acc_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) state <= EXEC;
        end
        EXEC: begin
          state     <= DONE;
          out_valid <= 1'b1;
          if (op_p0 == ALU_RSV) begin
            // Reserved op: flag it, leave accumulator and counter alone.
            out_res <= '0;
            out_n   <= 1'b0;
            out_z   <= 1'b0;
            out_c   <= 1'b0;
            out_v   <= 1'b0;
            out_err <= 1'b1;
          end else begin
            out_res  <= core_res;
            out_n    <= core_n;
            out_z    <= core_z;
            out_c    <= core_c;
            out_v    <= core_v;
            out_err  <= 1'b0;
            acc_q    <= core_res;
            op_count <= op_count + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= in_valid ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
